// File: rtl/trace_readout.sv
// trace_readout: read-side engine for the capture buffer RAM. Walks a circular window of
//   words starting at StartAddress and serializes each word LSB byte first onto a
//   valid/ready byte stream for the host link transmitter.
// Latency: Start at cycle 0 -> FETCH at cycle 1 -> first TxValid at cycle 2; BYTES+1 cycles
//   per word when TxReady is held high (one FETCH bubble per word).
// Backpressure: TxData/TxValid hold while TxValid & !TxReady; the engine stalls in SEND
//   (or HEADER) until the byte is accepted. Start is ignored unless idle.
// Optional feature macro: TRACE_READOUT_HEADER_EN (3-byte header A5, Count lo, Count hi).
// Ports:
//   Clock, Reset (sync, active-high), Start/StartAddress/Count (request, latched in IDLE),
//   RdAddress/RdClockEn/Q (combinational RAM read port), TxData/TxValid/TxReady (byte
//   stream), Busy (transfer in progress), Done (1-cycle end-of-transfer pulse).
module trace_readout #(
  parameter int adrbits  = 12,
  parameter int databits = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [adrbits-1:0]  StartAddress,
  input  logic [adrbits:0]    Count,
  output logic [adrbits-1:0]  RdAddress,
  output logic                RdClockEn,
  input  logic [databits-1:0] Q,
  output logic [7:0]          TxData,
  output logic                TxValid,
  input  logic                TxReady,
  output logic                Busy,
  output logic                Done
);

  localparam int BYTES = (databits + 7) / 8;
  localparam int WBITS = BYTES * 8;

  typedef enum logic [2:0] {
    IDLE,
`ifdef TRACE_READOUT_HEADER_EN
    HEADER,
`endif
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [adrbits-1:0] addr;
  logic [adrbits:0]   remain;     // words still to fetch
  logic [WBITS-1:0]   word;       // zero-padded word, shifted right as bytes go out
  logic [7:0]         byte_idx;
  logic               last_byte;

`ifdef TRACE_READOUT_HEADER_EN
  // hdr_idx 0 is a one-cycle bubble so the first header byte appears at the same
  // cycle a first payload byte would without the header; 1..3 select the header byte.
  logic [1:0]         hdr_idx;
  logic [15:0]        cnt16;
  logic [7:0]         hdr_byte;

  assign cnt16 = 16'(remain);

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      2'd1:    hdr_byte = 8'hA5;
      2'd2:    hdr_byte = cnt16[7:0];
      2'd3:    hdr_byte = cnt16[15:8];
      default: hdr_byte = 8'h00;
    endcase
  end
`endif

  assign RdAddress = addr;
  assign last_byte = (byte_idx == 8'(BYTES - 1));

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    RdClockEn = 1'b0;
    TxValid   = 1'b0;
    TxData    = 8'h00;
    Busy      = (state != IDLE);
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef TRACE_READOUT_HEADER_EN
          state_nxt = HEADER;
`else
          state_nxt = (Count == '0) ? DONE : FETCH;
`endif
        end
      end
`ifdef TRACE_READOUT_HEADER_EN
      HEADER: begin
        TxValid = (hdr_idx != 2'd0);
        TxData  = hdr_byte;
        if (hdr_idx == 2'd3 && TxReady)
          state_nxt = (remain == '0) ? DONE : FETCH;
      end
`endif
      FETCH: begin
        RdClockEn = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        TxValid = 1'b1;
        TxData  = word[7:0];
        if (TxReady && last_byte)
          state_nxt = (remain != '0) ? FETCH : DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address/count window, word serializer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr     <= '0;
      remain   <= '0;
      word     <= '0;
      byte_idx <= '0;
`ifdef TRACE_READOUT_HEADER_EN
      hdr_idx  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            addr    <= StartAddress;
            remain  <= Count;
`ifdef TRACE_READOUT_HEADER_EN
            hdr_idx <= '0;
`endif
          end
        end
`ifdef TRACE_READOUT_HEADER_EN
        HEADER: begin
          if (hdr_idx == 2'd0)
            hdr_idx <= 2'd1;
          else if (TxReady && hdr_idx != 2'd3)
            hdr_idx <= hdr_idx + 2'd1;
        end
`endif
        FETCH: begin
          word     <= WBITS'(Q);
          addr     <= addr + adrbits'(1);        // wraps modulo buffer depth
          remain   <= remain - (adrbits + 1)'(1);
          byte_idx <= '0;
        end
        SEND: begin
          if (TxReady) begin
            word     <= word >> 8;
            byte_idx <= byte_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
